// File: rtl/bias_buf_pkg.sv
// Shared types and constants for the bias SRAM controller.
// FIFO depth derives from the SRAM read latency.
package bias_buf_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        READ  = 2'd2,
        DRAIN = 2'd3
    } state_t;

    localparam int STALL_W = 16;

    // Latency plus two slots sustains one word per cycle under full rate.
    function automatic int fifo_depth(input int n_delay);
        return n_delay + 2;
    endfunction

endpackage

// File: rtl/bias_rd_fifo.sv
// Small synchronous FIFO with a registered head word.
// Absorbs SRAM read latency ahead of the output stream.
module bias_rd_fifo #(
    parameter int DW    = 16,
    parameter int DEPTH = 3
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic                       push,
    input  logic                       pop,
    input  logic [DW-1:0]              din,
    output logic [DW-1:0]              dout,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       empty
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH+1);

    logic [DW-1:0] mem [DEPTH];
    logic [PW-1:0] wp;
    logic [PW-1:0] rp;
    logic          pop_ok;

    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
        return (p == PW'(DEPTH-1)) ? '0 : p + 1'b1;
    endfunction

    assign empty  = (count == '0);
    assign pop_ok = pop && !empty;

    always_ff @(posedge clk) begin
        if (push) mem[wp] <= din;
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            wp    <= '0;
            rp    <= '0;
            count <= '0;
            dout  <= '0;
        end else begin
            if (push)   wp <= nxt(wp);
            if (pop_ok) rp <= nxt(rp);
            if (push && !pop_ok)      count <= count + 1'b1;
            else if (!push && pop_ok) count <= count - 1'b1;
            // Head register tracks whatever word will be at the front next.
            if (push && (empty || (pop_ok && count == CW'(1))))
                dout <= din;
            else if (pop_ok && count > CW'(1))
                dout <= mem[nxt(rp)];
        end
    end

endmodule

// File: rtl/bias_buf_ctrl.sv
// Load/read-out controller for the single-port bias SRAM.
// Define BIAS_BUF_STALL_CNT_EN to build the output-stall counter.
module bias_buf_ctrl
    import bias_buf_pkg::*;
#(
    parameter int DW      = 16,
    parameter int AW      = 4,
    parameter int DEPTH   = 16,
    parameter int N_DELAY = 1
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               ld_start,
    input  logic [AW-1:0]      ld_base,
    input  logic [AW:0]        ld_len,
    input  logic               s_valid,
    output logic               s_ready,
    input  logic [DW-1:0]      s_data,
    input  logic               rd_start,
    input  logic [AW-1:0]      rd_base,
    input  logic [AW:0]        rd_len,
    output logic               m_valid,
    input  logic               m_ready,
    output logic [DW-1:0]      m_data,
    output logic               busy,
    output logic               ld_done,
    output logic               rd_done,
    output logic [STALL_W-1:0] stall_cnt,
    output logic               mem_cs,
    output logic               mem_we,
    output logic [AW-1:0]      mem_addr,
    output logic [DW-1:0]      mem_wdata,
    input  logic [DW-1:0]      mem_rdata
);

    localparam int FD = fifo_depth(N_DELAY);
    localparam int CW = $clog2(FD+1);

    state_t         state;
    state_t         state_nx;
    logic [AW-1:0]  addr;
    logic [AW-1:0]  addr_nx;
    logic [AW-1:0]  addr_inc;
    logic [AW:0]    cnt;
    logic [AW:0]    cnt_nx;
    logic [AW:0]    out_cnt;
    logic           zlen;
    logic [N_DELAY-1:0] sr;
    logic           ld_done_q;
    logic           ld_fin;
    logic           issue;
    logic           rd_acc;
    logic           push;
    logic           pop;
    logic           fempty;
    logic [CW-1:0]  fcount;
    logic [CW-1:0]  inflight;
    logic [DW-1:0]  fdout;

    assign addr_inc = (addr == AW'(DEPTH-1)) ? '0 : addr + 1'b1;
    assign rd_acc   = (state == IDLE) && !ld_start && rd_start;

    always_comb begin
        inflight = '0;
        for (int i = 0; i < N_DELAY; i++)
            inflight = inflight + CW'(sr[i]);
    end

    always_comb begin
        state_nx  = state;
        addr_nx   = addr;
        cnt_nx    = cnt;
        s_ready   = 1'b0;
        mem_cs    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        issue     = 1'b0;
        ld_fin    = 1'b0;
        unique case (state)
            IDLE: begin
                if (ld_start) begin
                    state_nx = LOAD;
                    addr_nx  = ld_base;
                    cnt_nx   = ld_len;
                end else if (rd_start) begin
                    addr_nx  = rd_base;
                    cnt_nx   = rd_len;
                    state_nx = (rd_len == '0) ? DRAIN : READ;
                end
            end
            LOAD: begin
                if (cnt == '0) begin
                    state_nx = IDLE;
                    ld_fin   = 1'b1;
                end else begin
                    s_ready = 1'b1;
                    if (s_valid) begin
                        mem_cs    = 1'b1;
                        mem_we    = 1'b1;
                        mem_addr  = addr;
                        mem_wdata = s_data;
                        addr_nx   = addr_inc;
                        cnt_nx    = cnt - 1'b1;
                        if (cnt == (AW+1)'(1)) begin
                            state_nx = IDLE;
                            ld_fin   = 1'b1;
                        end
                    end
                end
            end
            READ: begin
                // Reserve a FIFO slot for every read still in the SRAM pipe.
                if ((fcount + inflight) < CW'(FD)) begin
                    issue    = 1'b1;
                    mem_cs   = 1'b1;
                    mem_addr = addr;
                    addr_nx  = addr_inc;
                    cnt_nx   = cnt - 1'b1;
                    if (cnt == (AW+1)'(1)) state_nx = DRAIN;
                end
            end
            DRAIN: begin
                if (inflight == '0 && fempty) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state     <= IDLE;
            addr      <= '0;
            cnt       <= '0;
            out_cnt   <= '0;
            zlen      <= 1'b0;
            sr        <= '0;
            ld_done_q <= 1'b0;
        end else begin
            state     <= state_nx;
            addr      <= addr_nx;
            cnt       <= cnt_nx;
            ld_done_q <= ld_fin;
            sr[0]     <= issue;
            for (int i = 1; i < N_DELAY; i++)
                sr[i] <= sr[i-1];
            if (rd_acc) begin
                out_cnt <= rd_len;
                zlen    <= (rd_len == '0);
            end else if (pop) begin
                out_cnt <= out_cnt - 1'b1;
            end
        end
    end

    assign push = sr[N_DELAY-1];
    assign pop  = !fempty && m_ready;

    bias_rd_fifo #(
        .DW    (DW),
        .DEPTH (FD)
    ) u_fifo (
        .clk   (clk),
        .rstn  (rstn),
        .push  (push),
        .pop   (pop),
        .din   (mem_rdata),
        .dout  (fdout),
        .count (fcount),
        .empty (fempty)
    );

    assign m_valid = !fempty;
    assign m_data  = fdout;
    assign busy    = (state != IDLE);
    assign ld_done = ld_done_q;
    assign rd_done = (pop && out_cnt == (AW+1)'(1)) ||
                     (state == DRAIN && zlen);

`ifdef BIAS_BUF_STALL_CNT_EN
    logic [STALL_W-1:0] stall_q;

    always_ff @(posedge clk) begin
        if (!rstn)
            stall_q <= '0;
        else if (rd_acc)
            stall_q <= '0;
        else if (m_valid && !m_ready && stall_q != '1)
            stall_q <= stall_q + 1'b1;
    end

    assign stall_cnt = stall_q;
`else
    assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_bias_buf_ctrl.sv
// Scoreboard bench for bias_buf_ctrl with an SRAM model.
// Driver queues expectations; a negedge monitor checks them.
module tb_bias_buf_ctrl;

    localparam int DW    = 16;
    localparam int AW    = 4;
    localparam int DEPTH = 16;
    localparam int ND    = 1;
    localparam int FD    = ND + 2;

    logic          clk = 1'b0;
    logic          rstn;
    logic          ld_start, rd_start;
    logic [AW-1:0] ld_base, rd_base;
    logic [AW:0]   ld_len, rd_len;
    logic          s_valid, s_ready;
    logic [DW-1:0] s_data;
    logic          m_valid, m_ready;
    logic [DW-1:0] m_data;
    logic          busy, ld_done, rd_done;
    logic [15:0]   stall_cnt;
    logic          mem_cs, mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;

    always #5 clk = ~clk;

    bias_buf_ctrl #(
        .DW(DW), .AW(AW), .DEPTH(DEPTH), .N_DELAY(ND)
    ) dut (
        .clk(clk), .rstn(rstn),
        .ld_start(ld_start), .ld_base(ld_base), .ld_len(ld_len),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .rd_start(rd_start), .rd_base(rd_base), .rd_len(rd_len),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
        .busy(busy), .ld_done(ld_done), .rd_done(rd_done),
        .stall_cnt(stall_cnt),
        .mem_cs(mem_cs), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    logic [DW-1:0] sram  [DEPTH];
    logic [DW-1:0] rpipe [ND];

    always @(posedge clk) begin
        if (mem_cs && mem_we) sram[mem_addr] <= mem_wdata;
        if (mem_cs && !mem_we) rpipe[0] <= sram[mem_addr];
        for (int i = 1; i < ND; i++) rpipe[i] <= rpipe[i-1];
    end
    assign mem_rdata = rpipe[ND-1];

    logic [DW-1:0] ref_mem [DEPTH];
    logic [AW-1:0] wa_q [$];
    logic [DW-1:0] wd_q [$];
    logic [AW-1:0] ra_q [$];
    logic [DW:0]   exp_q [$];
    logic [DW:0]   e;
    int checks = 0;
    int errors = 0;
    int zlen_pend = 0;
    int stall_exp = 0;
    int issued = 0;
    int popped = 0;
    int rdy_mode = 0;
    int rdy_ph = 0;
    logic          prev_stall = 1'b0;
    logic [DW-1:0] prev_data = '0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always begin
        @(posedge clk);
        #1;
        rdy_ph = (rdy_ph + 1) % 4;
        case (rdy_mode)
            0:       m_ready = 1'b1;
            1:       m_ready = 1'($urandom_range(0, 1));
            2:       m_ready = (rdy_ph == 0 || rdy_ph == 3);
            default: m_ready = 1'b0;
        endcase
    end

    always @(negedge clk) begin
        if (!rstn) begin
            wa_q.delete(); wd_q.delete(); ra_q.delete(); exp_q.delete();
            prev_stall = 1'b0;
            issued = 0; popped = 0; zlen_pend = 0; stall_exp = 0;
        end else begin
            if (mem_cs && mem_we) begin
                if (wa_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL wr_unexp: write addr %0h data %0h, none expected",
                             mem_addr, mem_wdata);
                end else begin
                    chk("wr_addr", 32'(mem_addr), 32'(wa_q.pop_front()));
                    chk("wr_data", 32'(mem_wdata), 32'(wd_q.pop_front()));
                end
            end
            if (mem_cs && !mem_we) begin
                issued++;
                if (ra_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL rd_unexp: read addr %0h, none expected", mem_addr);
                end else begin
                    chk("rd_addr", 32'(mem_addr), 32'(ra_q.pop_front()));
                end
                chk("fifo_bound", 32'((issued - popped) <= FD), 32'(1));
            end
            if (prev_stall) begin
                chk("hold_valid", 32'(m_valid), 32'(1));
                chk("hold_data", 32'(m_data), 32'(prev_data));
            end
            if (m_valid && m_ready) begin
                popped++;
                if (exp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL out_unexp: word %0h, none expected", m_data);
                end else begin
                    e = exp_q.pop_front();
                    chk("rd_data", 32'(m_data), 32'(e[DW-1:0]));
                    chk("rd_done_last", 32'(rd_done), 32'(e[DW]));
                end
            end else if (rd_done) begin
                checks++;
                if (zlen_pend > 0) zlen_pend--;
                else begin
                    errors++;
                    $display("FAIL rd_done_unexp: got 1 expected 0");
                end
            end
            prev_stall = m_valid && !m_ready;
            prev_data  = m_data;
            if (prev_stall) stall_exp++;
        end
    end

    task automatic chk_reset();
        chk("rst_ctrl", 32'({s_ready, m_valid, busy, ld_done, rd_done,
                             mem_cs, mem_we}), 32'(0));
        chk("rst_addr", 32'(mem_addr), 32'(0));
        chk("rst_wdata", 32'(mem_wdata), 32'(0));
        chk("rst_mdata", 32'(m_data), 32'(0));
        chk("rst_stall", 32'(stall_cnt), 32'(0));
    endtask

    task automatic wait_idle();
        int n = 0;
        @(negedge clk);
        while (busy && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk("idle_timeout", 32'(busy), 32'(0));
    endtask

    task automatic do_load(input int base, input int len, input bit rnd,
                           input bit fixed, input bit both, input bit tput);
        logic [DW-1:0] words [DEPTH];
        logic [AW-1:0] a;
        int  t = 0;
        int  nacc = 0;
        bit  acc;
        wait_idle();
        @(posedge clk); #1;
        for (int i = 0; i < len; i++) begin
            a = AW'((base + i) % DEPTH);
            words[i] = fixed ? DW'(16'h0100 + i) : DW'($urandom);
            wa_q.push_back(a);
            wd_q.push_back(words[i]);
            ref_mem[a] = words[i];
        end
        ld_start = 1'b1;
        ld_base  = AW'(base);
        ld_len   = (AW+1)'(len);
        if (both) begin
            rd_start = 1'b1;
            rd_base  = AW'($urandom);
            rd_len   = (AW+1)'($urandom_range(1, DEPTH));
        end
        if (len == 0) begin
            @(posedge clk); #1;
            ld_start = 1'b0; rd_start = 1'b0;
            @(posedge clk); #1;
        end
        while (nacc < len && t < 600) begin
            s_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            s_data  = words[nacc];
            @(negedge clk);
            acc = s_valid && s_ready;
            @(posedge clk); #1;
            ld_start = 1'b0; rd_start = 1'b0;
            if (acc) nacc++;
            t++;
        end
        s_valid = 1'b0;
        chk("ld_accepts", 32'(nacc), 32'(len));
        if (tput) chk("ld_tput", 32'(t), 32'(len + 1));
        @(negedge clk);
        chk("ld_done", 32'(ld_done), 32'(1));
        chk("ld_busy", 32'(busy), 32'(0));
    endtask

    task automatic rd_setup(input int base, input int len, input int mode);
        logic [AW-1:0] a;
        rdy_mode  = mode;
        stall_exp = 0;
        for (int i = 0; i < len; i++) begin
            a = AW'((base + i) % DEPTH);
            ra_q.push_back(a);
            exp_q.push_back({(i == len - 1), ref_mem[a]});
        end
        if (len == 0) zlen_pend++;
        rd_start = 1'b1;
        rd_base  = AW'(base);
        rd_len   = (AW+1)'(len);
        @(posedge clk); #1;
        rd_start = 1'b0;
    endtask

    task automatic do_read(input int base, input int len, input int mode,
                           input bit lat);
        int t = 1;
        wait_idle();
        @(posedge clk); #1;
        rd_setup(base, len, mode);
        if (lat) begin
            while (t < 50) begin
                @(negedge clk);
                if (m_valid) break;
                @(posedge clk); #1;
                t++;
            end
            chk("rd_latency", 32'(t), 32'(2 + ND));
            for (int i = 1; i < len; i++) begin
                @(posedge clk); #1;
                @(negedge clk);
                chk("rd_stream", 32'(m_valid), 32'(1));
            end
        end
        wait_idle();
        chk("rd_drained", 32'(exp_q.size() + ra_q.size()), 32'(0));
        chk("zlen_done", 32'(zlen_pend), 32'(0));
`ifdef BIAS_BUF_STALL_CNT_EN
        chk("stall_cnt", 32'(stall_cnt), 32'(stall_exp));
`else
        chk("stall_cnt", 32'(stall_cnt), 32'(0));
`endif
    endtask

    initial begin
        rstn = 1'b0;
        ld_start = 1'b0; rd_start = 1'b0;
        ld_base = '0; rd_base = '0; ld_len = '0; rd_len = '0;
        s_valid = 1'b0; s_data = '0; m_ready = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            sram[i] = '0;
            ref_mem[i] = '0;
        end
        for (int i = 0; i < ND; i++) rpipe[i] = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_reset();
        @(posedge clk); #1;
        rstn = 1'b1;

        do_load(0, 16, 1'b0, 1'b1, 1'b0, 1'b1);
        do_read(0, 16, 0, 1'b1);
        do_read(14, 4, 0, 1'b0);
        do_read(3, 8, 2, 1'b0);
        do_load($urandom_range(0, 15), $urandom_range(1, 16),
                1'b0, 1'b0, 1'b1, 1'b0);
        do_read(0, 16, 1, 1'b0);
        do_read(5, 0, 1, 1'b0);

        wait_idle();
        @(posedge clk); #1;
        rd_setup(int'($urandom_range(0, 15)), 8, 3);
        @(posedge clk); #1;
        rstn = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        chk_reset();
        @(posedge clk); #1;
        rstn = 1'b1;
        do_read(int'($urandom_range(0, 15)), 8, 1, 1'b0);

        repeat (20) begin
            do_load(int'($urandom_range(0, 15)), int'($urandom_range(0, 16)),
                    1'b1, 1'b0, 1'b0, 1'b0);
            repeat (2)
                do_read(int'($urandom_range(0, 15)), int'($urandom_range(0, 16)),
                        1, 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
